// File: rtl/axi_simple_master.sv
// AXI4 initiator: one core request at a time -> INCR read burst or single-beat write.
// Optional watchdog with sticky timeout flag when AXI_MASTER_TIMEOUT_EN is defined.
module axi_simple_master #(
    parameter logic [3:0] AXI_ID  = 4'd0,
    parameter int         TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [7:0]  req_len,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_last,
    output logic        resp_wr,
    output logic        resp_err,
`ifdef AXI_MASTER_TIMEOUT_EN
    output logic        timeout,
`endif
    output logic [3:0]  m_axi_awid,
    output logic [31:0] m_axi_awaddr,
    output logic [7:0]  m_axi_awlen,
    output logic [2:0]  m_axi_awsize,
    output logic [1:0]  m_axi_awburst,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wlast,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [3:0]  m_axi_bid,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [3:0]  m_axi_arid,
    output logic [31:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [3:0]  m_axi_rid,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rlast,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, WRSP} state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_q;
    logic [7:0]  len_q;
    logic [2:0]  size_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_done, w_done;
    logic [1:0]  bresp_q;
    logic [7:0]  cnt;
    logic        rst_done;
    logic        aw_fin, w_fin;

    // IDs are not checked: only one transaction is ever in flight.
    logic [7:0] unused_ids;
    assign unused_ids = {m_axi_bid, m_axi_rid};

    assign aw_fin = aw_done | m_axi_awready;
    assign w_fin  = w_done  | m_axi_wready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid && req_ready) state_nxt = req_wr ? AW_W : AR;
            AR:      if (m_axi_arready) state_nxt = R;
            R:       if (m_axi_rvalid && m_axi_rready && m_axi_rlast) state_nxt = IDLE;
            AW_W:    if (aw_fin && w_fin) state_nxt = B;
            B:       if (m_axi_bvalid) state_nxt = WRSP;
            WRSP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            bresp_q  <= '0;
            cnt      <= '0;
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            if (state == IDLE && req_valid && req_ready) begin
                addr_q  <= req_addr;
                len_q   <= req_wr ? 8'd0 : req_len;
                size_q  <= req_size;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                cnt     <= '0;
            end
            if (m_axi_awvalid && m_axi_awready) aw_done <= 1'b1;
            if (m_axi_wvalid && m_axi_wready)   w_done  <= 1'b1;
            if (m_axi_rvalid && m_axi_rready)   cnt     <= cnt + 8'd1;
            if (state == B && m_axi_bvalid)     bresp_q <= m_axi_bresp;
        end
    end

    always_comb begin
        req_ready     = (state == IDLE) && rst_done;
        m_axi_arid    = AXI_ID;
        m_axi_araddr  = addr_q;
        m_axi_arlen   = len_q;
        m_axi_arsize  = size_q;
        m_axi_arburst = 2'b01;
        m_axi_arvalid = (state == AR);
        m_axi_awid    = AXI_ID;
        m_axi_awaddr  = addr_q;
        m_axi_awlen   = 8'd0;
        m_axi_awsize  = size_q;
        m_axi_awburst = 2'b01;
        m_axi_awvalid = (state == AW_W) && !aw_done;
        m_axi_wdata   = wdata_q;
        m_axi_wstrb   = wstrb_q;
        m_axi_wlast   = 1'b1;
        m_axi_wvalid  = (state == AW_W) && !w_done;
        m_axi_bready  = (state == B);
        m_axi_rready  = 1'b0;
        resp_valid    = 1'b0;
        resp_rdata    = '0;
        resp_last     = 1'b0;
        resp_wr       = 1'b0;
        resp_err      = 1'b0;
        if (state == R) begin
            // Zero-latency pass-through: the core's ready backpressures the slave directly.
            m_axi_rready = resp_ready;
            resp_valid   = m_axi_rvalid;
            resp_rdata   = m_axi_rdata;
            resp_last    = m_axi_rlast;
            resp_err     = (m_axi_rresp != 2'b00) || (m_axi_rlast != (cnt == len_q));
        end else if (state == WRSP) begin
            resp_valid = 1'b1;
            resp_wr    = 1'b1;
            resp_last  = 1'b1;
            resp_err   = (bresp_q != 2'b00);
        end
    end

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam logic [15:0] WD_LIM = 16'(TIMEOUT - 1);
    logic [15:0] wd_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else if (state_nxt != state) begin
            wd_cnt <= '0;
        end else if (state != IDLE && wd_cnt != 16'hFFFF) begin
            wd_cnt <= wd_cnt + 16'd1;
            if (wd_cnt == WD_LIM) timeout <= 1'b1;
        end
    end
`else
    logic [15:0] unused_timeout;
    assign unused_timeout = 16'(TIMEOUT);
`endif

endmodule
